// File: rtl/mem_bus_arbiter.sv
// Purpose: round-robin two-master arbiter onto the shared data-side memory bus (RAM, boot ROM port 2, GPO).
// Latency: write ack 1 cycle after the request is seen in IDLE; read ack and data 2 cycles after it.
// Backpressure: a master holds req until its ack; requests that arrive mid-transfer wait for the next IDLE.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int WIDTH_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m0_req,
    input  logic               m0_write,
    input  logic [ADDR_W-1:0]  m0_addr,
    input  logic [DATA_W-1:0]  m0_wdata,
    input  logic [WIDTH_W-1:0] m0_width,
    output logic               m0_ack,
    output logic [DATA_W-1:0]  m0_rdata,
    input  logic               m1_req,
    input  logic               m1_write,
    input  logic [ADDR_W-1:0]  m1_addr,
    input  logic [DATA_W-1:0]  m1_wdata,
    input  logic [WIDTH_W-1:0] m1_width,
    output logic               m1_ack,
    output logic [DATA_W-1:0]  m1_rdata,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [WIDTH_W-1:0] mem_width,
    output logic               mem_write,
    input  logic [DATA_W-1:0]  rom_rdata,
    input  logic [DATA_W-1:0]  ram_rdata,
    output logic               busy
);

    // Address bit 9 splits the map: 0 = boot ROM, 1 = data RAM.
    localparam int RAM_SEL_BIT = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic                sel_ram_q, sel_ram_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

    logic                own_write;
    logic [ADDR_W-1:0]   own_addr;
    logic [DATA_W-1:0]   own_wdata;
    logic [WIDTH_W-1:0]  own_width;
    logic [DATA_W-1:0]   rd_mux;
    logic                winner;
    logic                ack;

    // Owner's request fields, selected once so the FSM body stays master-agnostic.
    assign own_write = owner_q ? m1_write : m0_write;
    assign own_addr  = owner_q ? m1_addr  : m0_addr;
    assign own_wdata = owner_q ? m1_wdata : m0_wdata;
    assign own_width = owner_q ? m1_width : m0_width;

    // Memories return data one cycle after the address, so the region chosen in ISSUE steers RDATA.
    assign rd_mux = sel_ram_q ? ram_rdata : rom_rdata;

    // On a tie the master that did not win last time gets the bus; otherwise the lone requester wins.
    assign winner = (m0_req && m1_req) ? ~last_q : m1_req;

    assign busy = (state_q != IDLE);

    // Next-state, bus drive and read-data capture; reset masks ack, strobe and data capture in the same cycle.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        sel_ram_d  = sel_ram_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        ack        = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_width  = '0;
        mem_write  = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    owner_d = winner;
                    last_d  = winner;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_addr  = own_addr;
                mem_wdata = own_wdata;
                mem_width = own_width;
                mem_write = own_write;
                sel_ram_d = own_addr[RAM_SEL_BIT];
                if (own_write) begin
                    ack     = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                mem_addr = own_addr;
                ack      = 1'b1;
                if (owner_q) begin
                    m1_rdata_d = rd_mux;
                end else begin
                    m0_rdata_d = rd_mux;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A transfer interrupted by reset is dropped: no ack, no strobe, no data update.
        if (rst) begin
            ack        = 1'b0;
            mem_write  = 1'b0;
            m0_rdata_d = m0_rdata_q;
            m1_rdata_d = m1_rdata_q;
        end
    end

    // Only the owner ever sees an ack.
    assign m0_ack = ack && !owner_q;
    assign m1_ack = ack &&  owner_q;

    // Read data is visible in the ack cycle itself and then held by the register.
    assign m0_rdata = m0_rdata_d;
    assign m1_rdata = m1_rdata_d;

    // State and data registers; last resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            sel_ram_q  <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            sel_ram_q  <= sel_ram_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose: scoreboard bench for mem_bus_arbiter with a ROM/RAM model behind the shared bus.
// Latency: expected ack cycle of every transfer is hand-computed relative to the cycle its req rises.
// Backpressure: per-master drivers hold req until ack, chaining queued commands back-to-back.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_write, m0_ack, m1_req, m1_write, m1_ack;
    logic [9:0]  m0_addr, m1_addr, mem_addr;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata;
    logic [3:0]  m0_width, m1_width, mem_width;
    logic        mem_write, busy;
    logic [31:0] rom_rdata, ram_rdata;

    mem_bus_arbiter #(.ADDR_W(10), .DATA_W(32), .WIDTH_W(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_width(m0_width), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_width(m1_width), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_width(mem_width),
        .mem_write(mem_write), .rom_rdata(rom_rdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int t0 = 0;
    int mon_m;
    logic abort0 = 1'b0;

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  width;
    } cmd_t;

    typedef struct {
        int          m;
        int          due;
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [3:0]  width;
    } exp_t;

    cmd_t cmd0_q[$];
    cmd_t cmd1_q[$];
    exp_t exp_q[$];
    cmd_t c0, c1;
    exp_t e;

    // Memory model: ROM word = 0xB0000000 | word index; RAM cleared on reset with word 0x204 preset.
    logic [31:0] ram [0:127];
    always @(posedge clk) begin
        rom_rdata <= 32'hB000_0000 | {25'd0, mem_addr[8:2]};
        ram_rdata <= ram[mem_addr[8:2]];
        if (rst) begin
            for (int i = 0; i < 128; i++) ram[i] <= 32'd0;
            ram[1] <= 32'h1234_5678;
        end else if (mem_write && mem_addr[9]) begin
            for (int b = 0; b < 4; b++)
                if (mem_width[b]) ram[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_m0_ack"},    32'(m0_ack),    32'd0);
        check({tag, "_m1_ack"},    32'(m1_ack),    32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        check({tag, "_mem_width"}, 32'(mem_width), 32'd0);
        check({tag, "_m0_rdata"},  m0_rdata,       32'd0);
        check({tag, "_m1_rdata"},  m1_rdata,       32'd0);
    endtask

    // Queue one transfer for master m; data is wdata for writes, expected rdata for reads; off = ack cycle - t0.
    task automatic issue(input int m, input logic wr, input logic [9:0] addr, input logic [31:0] data,
                         input logic [3:0] width, input int off);
        cmd_t c;
        exp_t x;
        c.wr = wr; c.addr = addr; c.wdata = wr ? data : 32'd0; c.width = width;
        if (m == 0) cmd0_q.push_back(c); else cmd1_q.push_back(c);
        x.m = m; x.due = t0 + off; x.wr = wr; x.addr = addr; x.data = data; x.width = width;
        exp_q.push_back(x);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || cmd0_q.size() != 0 || cmd1_q.size() != 0 || m0_req || m1_req)
               && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d acks still outstanding after %0d cycles", exp_q.size(), budget);
            exp_q.delete(); cmd0_q.delete(); cmd1_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Drivers: just after the falling edge, raise req for the next queued command or drop it after ack.
    initial begin
        m0_req = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0; m0_width = '0;
        m1_req = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0; m1_width = '0;
        forever begin
            @(negedge clk);
            #1;
            if (abort0) begin
                m0_req = 0;
                cmd0_q.delete();
            end else if (m0_ack || !m0_req) begin
                if (cmd0_q.size() > 0) begin
                    c0 = cmd0_q.pop_front();
                    m0_req = 1; m0_write = c0.wr; m0_addr = c0.addr; m0_wdata = c0.wdata; m0_width = c0.width;
                end else begin
                    m0_req = 0;
                end
            end
            if (m1_ack || !m1_req) begin
                if (cmd1_q.size() > 0) begin
                    c1 = cmd1_q.pop_front();
                    m1_req = 1; m1_write = c1.wr; m1_addr = c1.addr; m1_wdata = c1.wdata; m1_width = c1.width;
                end else begin
                    m1_req = 0;
                end
            end
        end
    end

    // Monitor: on every ack pop the scoreboard and compare master, cycle, bus drive and read data.
    initial begin
        forever begin
            @(negedge clk);
            if (m0_ack && m1_ack) check("both_acks", 32'd1, 32'd0);
            if (m0_ack || m1_ack) begin
                mon_m = m1_ack ? 1 : 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: m%0d acked at cycle %0d, none expected", mon_m, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_master", 32'(mon_m), 32'(e.m));
                    check("ack_cycle", 32'(cyc), 32'(e.due));
                    check("mem_write", 32'(mem_write), 32'(e.wr));
                    check("mem_addr", 32'(mem_addr), 32'(e.addr));
                    if (e.wr) begin
                        check("mem_wdata", mem_wdata, e.data);
                        check("mem_width", 32'(mem_width), 32'(e.width));
                    end else begin
                        check("rdata", mon_m ? m1_rdata : m0_rdata, e.data);
                    end
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        logic [9:0] a;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 0;
        @(posedge clk);
        #1;

        // Single byte write to RAM: strobe and ack one cycle after req.
        t0 = cyc; issue(0, 1'b1, 10'h200, 32'h0000_00AA, 4'b0001, 1); wait_done(20);
        // Separate reads from ROM and RAM: ack two cycles after req.
        t0 = cyc; issue(1, 1'b0, 10'h004, 32'hB000_0001, 4'hF, 2); wait_done(20);
        t0 = cyc; issue(1, 1'b0, 10'h204, 32'h1234_5678, 4'hF, 2); wait_done(20);
        // Read back the byte write; upper lanes were never written.
        t0 = cyc; issue(0, 1'b0, 10'h200, 32'h0000_00AA, 4'hF, 2); wait_done(20);

        // Both read in the first cycle after reset: m0 first, m1 three cycles later.
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst2");
        rst = 0;
        t0 = cyc;
        issue(0, 1'b0, 10'h008, 32'hB000_0002, 4'hF, 2);
        issue(1, 1'b0, 10'h204, 32'h1234_5678, 4'hF, 5);
        wait_done(30);

        // Sustained contention, 8 transfers: m0 writes (5-cycle period), m1 reads interleave.
        t0 = cyc;
        for (int k = 0; k < 4; k++) begin
            a = 10'(32'h210 + 4 * k);
            issue(0, 1'b1, a, 32'hC0DE_0000 + k, 4'hF, 1 + 5 * k);
            a = 10'(32'h00C + 4 * k);
            issue(1, 1'b0, a, 32'hB000_0003 + k, 4'hF, 4 + 5 * k);
        end
        wait_done(100);
        t0 = cyc; issue(0, 1'b0, 10'h21C, 32'hC0DE_0003, 4'hF, 2); wait_done(20);

        // Reset in the RDATA cycle of an m0 read: ack suppressed, data not captured.
        t0 = cyc;
        c0.wr = 1'b0; c0.addr = 10'h204; c0.wdata = 32'd0; c0.width = 4'hF;
        cmd0_q.push_back(c0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rdata_state_busy", 32'(busy), 32'd1);
        rst = 1;
        abort0 = 1;
        @(negedge clk);
        check("rst_m0_ack", 32'(m0_ack), 32'd0);
        @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'd0);
        rst = 0;
        abort0 = 0;
        @(posedge clk);
        #1;

        // Write-then-read coherence across masters.
        t0 = cyc; issue(1, 1'b1, 10'h208, 32'hDEAD_BEEF, 4'hF, 1); wait_done(20);
        t0 = cyc; issue(0, 1'b0, 10'h208, 32'hDEAD_BEEF, 4'hF, 2); wait_done(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
